// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults.
//   tx_state_t  transmitter frame states (3-bit encoding)
//   UART_TICKS_PER_BIT_DEFAULT / UART_DATA_BITS_DEFAULT  default framing
//   calcParity  even parity of a zero-padded byte, optionally inverted
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int UART_TICKS_PER_BIT_DEFAULT = 16;
  localparam int UART_DATA_BITS_DEFAULT     = 8;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calcParity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts baud Ticks and flags the last Tick of a bit period.
//   Clock   system clock
//   ResetN  asynchronous active-low reset
//   Tick    one-Clock pulse from the baud-rate generator
//   Clear   holds the counter at zero (used while the owner is idle)
//   BitEnd  Tick arriving while the counter sits at TICKS_PER_BIT-1
module uart_tx_bit_timer #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic Tick,
  input  logic Clear,
  output logic BitEnd
);

  localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] tickCount_r;
  logic          atLast_s;

  assign atLast_s = (tickCount_r == LAST_C);
  assign BitEnd   = Tick & atLast_s;

  // Tick counter: advances only on Tick, wraps at the end of a bit.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      tickCount_r <= ZERO_C;
    end else if (Clear) begin
      tickCount_r <= ZERO_C;
    end else if (Tick) begin
      if (atLast_s) begin
        tickCount_r <= ZERO_C;
      end else begin
        tickCount_r <= tickCount_r + ONE_C;
      end
    end else begin
      tickCount_r <= tickCount_r;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: UART TX serializer (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits), paced by a 16x baud Tick.
//   Clock    system clock
//   ResetN   asynchronous active-low reset (Tx returns high at once)
//   Tick     one-Clock pulse from the baud-rate generator
//   TxStart  send request, sampled only while idle
//   TxData   byte captured on the accepted TxStart
//   Tx       registered serial line, idles high
//   TxBusy   high from the cycle after acceptance until frame end
//   TxDone   one-Clock pulse as the last stop bit completes
// Build option: define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD
// selects odd parity).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = UART_DATA_BITS_DEFAULT,
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS     = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD    = 0
`endif
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 Tx,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam logic [2:0] LAST_DATA_C = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_C = 3'(STOP_BITS - 1);

  tx_state_t            state_r, nextState_s;
  logic [2:0]           bitCount_r, nextBitCount_s;
  logic [DATA_BITS-1:0] shift_r, nextShift_s;
  logic                 nextTx_s, nextBusy_s, nextDone_s;
  logic                 bitEnd_s, clearTimer_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r, nextParity_s;
  logic [7:0]           paddedData_s;
`endif

  // The counter restarts from zero at every acceptance because it is held clear while idle.
  assign clearTimer_s = (state_r == TX_IDLE);

  uart_tx_bit_timer #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) bitTimer (
    .Clock (Clock),
    .ResetN(ResetN),
    .Tick  (Tick),
    .Clear (clearTimer_s),
    .BitEnd(bitEnd_s)
  );

  // Next-state logic; outputs are derived from the next state so they register with it.
  always_comb begin
    nextState_s    = state_r;
    nextBitCount_s = bitCount_r;
    nextShift_s    = shift_r;
    nextDone_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
    nextParity_s   = parity_r;
    paddedData_s   = 8'h00;
    paddedData_s[DATA_BITS-1:0] = TxData;
`endif
    case (state_r)
      TX_IDLE: begin
        if (TxStart) begin
          nextState_s    = TX_START;
          nextShift_s    = TxData;
          nextBitCount_s = 3'd0;
`ifdef UART_TX_PARITY_EN
          nextParity_s   = calcParity(paddedData_s, (PARITY_ODD != 0));
`endif
        end else begin
          nextState_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (bitEnd_s) begin
          nextState_s    = TX_DATA;
          nextBitCount_s = 3'd0;
        end else begin
          nextState_s = TX_START;
        end
      end
      TX_DATA: begin
        if (bitEnd_s) begin
          nextShift_s = shift_r >> 1'b1;
          if (bitCount_r == LAST_DATA_C) begin
`ifdef UART_TX_PARITY_EN
            nextState_s = TX_PARITY;
`else
            nextState_s = TX_STOP;
`endif
            nextBitCount_s = 3'd0;
          end else begin
            nextBitCount_s = bitCount_r + 3'd1;
          end
        end else begin
          nextState_s = TX_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bitEnd_s) begin
          nextState_s    = TX_STOP;
          nextBitCount_s = 3'd0;
        end else begin
          nextState_s = TX_PARITY;
        end
      end
`endif
      TX_STOP: begin
        if (bitEnd_s) begin
          if (bitCount_r == LAST_STOP_C) begin
            nextState_s    = TX_IDLE;
            nextBitCount_s = 3'd0;
            nextDone_s     = 1'b1;
          end else begin
            nextBitCount_s = bitCount_r + 3'd1;
          end
        end else begin
          nextState_s = TX_STOP;
        end
      end
      default: begin
        nextState_s    = TX_IDLE;
        nextBitCount_s = 3'd0;
      end
    endcase

    case (nextState_s)
      TX_IDLE:   nextTx_s = 1'b1;
      TX_START:  nextTx_s = 1'b0;
      TX_DATA:   nextTx_s = nextShift_s[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: nextTx_s = nextParity_s;
`endif
      TX_STOP:   nextTx_s = 1'b1;
      default:   nextTx_s = 1'b1;
    endcase

    nextBusy_s = (nextState_s != TX_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r    <= TX_IDLE;
      bitCount_r <= 3'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      Tx         <= 1'b1;
      TxBusy     <= 1'b0;
      TxDone     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= nextState_s;
      bitCount_r <= nextBitCount_s;
      shift_r    <= nextShift_s;
      Tx         <= nextTx_s;
      TxBusy     <= nextBusy_s;
      TxDone     <= nextDone_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= nextParity_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized and directed stimulus against a frame-level
// reference model (bit list of the frame, indexed by Ticks since acceptance).
module tb_uart_transmitter;

  localparam int DB  = 8;
  localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int FRAME_TICKS = (1 + DB + PB + SB) * TPB;

  logic       Clock;
  logic       ResetN;
  logic       Tick;
  logic       TxStart;
  logic [7:0] TxData;
  logic       Tx;
  logic       TxBusy;
  logic       TxDone;

  int tickPeriod = 24;
  int compareCount = 0;
  int mismatchCount = 0;

  // reference model state
  bit   mBusy = 1'b0;
  int   tickIdx = 0;
  int   mLen = 0;
  logic mBits [0:15];
  int   acceptCount = 0;
  int   doneCount = 0;
  int   busyTicks = 0;
  int   lastFrameTicks = 0;
  bit   prevBusy = 1'b0;
  bit   prevTx = 1'b1;
  int   cyc = 0;
  int   lastDoneCyc = 0;
  int   gapAtFall = 0;

  uart_transmitter #(
    .DATA_BITS    (DB),
    .TICKS_PER_BIT(TPB),
    .STOP_BITS    (SB)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD   (0)
`endif
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Tick   (Tick),
    .TxStart(TxStart),
    .TxData (TxData),
    .Tx     (Tx),
    .TxBusy (TxBusy),
    .TxDone (TxDone)
  );

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // baud tick generator, one pulse every tickPeriod clocks
  initial begin
    int tickCnt;
    tickCnt = 0;
    Tick = 1'b0;
    forever begin
      @(negedge Clock);
      tickCnt++;
      if (tickCnt >= tickPeriod) begin
        Tick = 1'b1;
        tickCnt = 0;
      end else begin
        Tick = 1'b0;
      end
    end
  end

  // reference model and per-cycle output checks
  always begin
    bit doneExp;
    logic expTx;
    @(posedge Clock);
    doneExp = 1'b0;
    if (!ResetN) begin
      mBusy = 1'b0;
      tickIdx = 0;
    end else if (mBusy) begin
      if (Tick) begin
        tickIdx++;
        if (tickIdx == mLen * TPB) begin
          mBusy = 1'b0;
          doneExp = 1'b1;
        end
      end
    end else if (TxStart) begin
      mLen = 0;
      mBits[mLen] = 1'b0; mLen++;
      for (int i = 0; i < DB; i++) begin
        mBits[mLen] = TxData[i]; mLen++;
      end
`ifdef UART_TX_PARITY_EN
      mBits[mLen] = ^TxData; mLen++;
`endif
      for (int i = 0; i < SB; i++) begin
        mBits[mLen] = 1'b1; mLen++;
      end
      mBusy = 1'b1;
      tickIdx = 0;
      acceptCount++;
    end
    if (ResetN && prevBusy && Tick) busyTicks++;
    #1;
    cyc++;
    expTx = mBusy ? mBits[tickIdx / TPB] : 1'b1;
    checkValue("Tx", {31'd0, Tx}, {31'd0, expTx});
    checkValue("TxBusy", {31'd0, TxBusy}, {31'd0, mBusy});
    checkValue("TxDone", {31'd0, TxDone}, {31'd0, doneExp});
    if (TxDone) begin
      doneCount++;
      lastFrameTicks = busyTicks;
      busyTicks = 0;
      lastDoneCyc = cyc;
    end
    if (prevTx && !Tx) gapAtFall = cyc - lastDoneCyc;
    prevTx = Tx;
    prevBusy = TxBusy;
    if (!ResetN) busyTicks = 0;
  end

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((mBusy || TxBusy) && n < budget) begin
      @(negedge Clock);
      n++;
    end
    checkValue("wait_idle", {31'd0, (n < budget)}, 32'd1);
  endtask

  task automatic waitTicks(input int target);
    int n;
    n = 0;
    while (!(mBusy && tickIdx >= target) && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    checkValue("wait_ticks", {31'd0, (n < 20000)}, 32'd1);
  endtask

  task automatic waitAccepts(input int target);
    int n;
    n = 0;
    while (acceptCount < target && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    checkValue("wait_accept", {31'd0, (n < 20000)}, 32'd1);
  endtask

  task automatic sendByte(input logic [7:0] d);
    waitIdle(20000);
    @(negedge Clock);
    TxData = d;
    TxStart = 1'b1;
    @(negedge Clock);
    TxStart = 1'b0;
    TxData = 8'($urandom);
  endtask

  initial begin
    int d0;
    int a0;
    ResetN = 1'b0;
    TxStart = 1'b0;
    TxData = 8'h00;
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    repeat (200) @(negedge Clock);

    // single frame 0x55, slow ticks
    d0 = doneCount;
    sendByte(8'h55);
    waitIdle(20000);
    checkValue("done_55", doneCount - d0, 32'd1);
    checkValue("len_55", lastFrameTicks, FRAME_TICKS);

    // busy ignore: second request mid-frame must be dropped
    tickPeriod = 6;
    d0 = doneCount;
    a0 = acceptCount;
    sendByte(8'hA3);
    waitTicks(40);
    TxData = 8'hFF;
    TxStart = 1'b1;
    @(negedge Clock);
    TxStart = 1'b0;
    waitIdle(20000);
    repeat (5) @(negedge Clock);
    checkValue("done_A3", doneCount - d0, 32'd1);
    checkValue("accept_A3", acceptCount - a0, 32'd1);

    // back-to-back with TxStart held high
    d0 = doneCount;
    a0 = acceptCount;
    @(negedge Clock);
    TxData = 8'h0F;
    TxStart = 1'b1;
    waitAccepts(a0 + 1);
    TxData = 8'hF0;
    waitAccepts(a0 + 2);
    TxStart = 1'b0;
    waitIdle(20000);
    checkValue("done_b2b", doneCount - d0, 32'd2);
    checkValue("gap_b2b", gapAtFall, 32'd1);

    // reset during data bit 3
    sendByte(8'h55);
    waitTicks(4 * TPB + 8);
    d0 = doneCount;
    ResetN = 1'b0;
    #1;
    checkValue("rst_Tx", {31'd0, Tx}, 32'd1);
    checkValue("rst_Busy", {31'd0, TxBusy}, 32'd0);
    checkValue("rst_Done", {31'd0, TxDone}, 32'd0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    repeat (3) @(negedge Clock);
    checkValue("rst_nodone", doneCount - d0, 32'd0);
    sendByte(8'h81);
    waitIdle(20000);
    checkValue("done_81", doneCount - d0, 32'd1);
    checkValue("len_81", lastFrameTicks, FRAME_TICKS);

`ifdef UART_TX_PARITY_EN
    sendByte(8'h07);
    waitIdle(20000);
    checkValue("len_par07", lastFrameTicks, 32'd192);
    sendByte(8'h03);
    waitIdle(20000);
    checkValue("len_par03", lastFrameTicks, 32'd192);
`endif

    // randomized frames, tick rates and ignored requests
    for (int k = 0; k < 10; k++) begin
      tickPeriod = $urandom_range(1, 4);
      d0 = doneCount;
      sendByte(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        waitTicks($urandom_range(1, FRAME_TICKS - 2));
        TxData = 8'($urandom);
        TxStart = 1'b1;
        @(negedge Clock);
        TxStart = 1'b0;
      end
      waitIdle(20000);
      repeat ($urandom_range(0, 5)) @(negedge Clock);
      checkValue("done_rand", doneCount - d0, 32'd1);
      checkValue("len_rand", lastFrameTicks, FRAME_TICKS);
    end

    repeat (5) @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
